// File: rtl/host_com_port_pkg.sv
// Shared definitions for the processor-side host link endpoint:
// default widths and the sequencer state encoding.
package host_com_port_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  // Encoding is visible on the state port, so values are fixed.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/host_com_port.sv
// Processor-side host link endpoint: loads the inbound word stream into
// data memory from address 0, pulses the cores, waits for them, then
// streams the result region back out and parks until reset.
module host_com_port
  import host_com_port_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int OUT_BASE = 0,
  parameter int OUT_LEN  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] com_data_in,
  input  logic              data_write_start,
  input  logic              data_write_done,
  input  logic              cores_done,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              cores_start,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
  output logic [1:0]        state,
  output logic              load_overflow
);

  // Counters run 0..OUT_LEN inclusive.
  localparam int CNT_W = $clog2(OUT_LEN + 1);

  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] BASE_NEXT = ADDR_W'(OUT_BASE + 1);
  localparam logic [CNT_W-1:0]  LEN_C     = CNT_W'(OUT_LEN);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);

  // The result region must be non-empty and fit inside the address space.
  if (OUT_LEN < 1 || OUT_BASE < 0 || OUT_BASE + OUT_LEN > (1 << ADDR_W)) begin : g_param_check
    $error("host_com_port: result region does not fit the address space");
  end

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    issue_cnt_q;   // read addresses issued so far
  logic [CNT_W-1:0]    out_cnt_q;     // result words already sent
  logic                addr_vld_q;    // mem_addr carries a read this cycle
  logic                data_vld_q;    // mem_rd_data holds a result word this cycle
  logic                mem_wr_en_q;
  logic [DATA_W-1:0]   mem_wr_data_q;
  logic                cores_start_q;
  logic [DATA_W-1:0]   com_data_out_q;
  logic                ows_q, owd_q;
  logic                load_overflow_q;

  assign wr_addr_d = wr_addr_q + ADDR_W'(1);
  assign rd_ptr_d  = rd_ptr_q + ADDR_W'(1);

  // Sequencer: load, one-cycle start pulse, wait, dump, hold; outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_LOAD;
      wr_addr_q       <= '0;
      rd_ptr_q        <= '0;
      mem_addr_q      <= '0;
      issue_cnt_q     <= '0;
      out_cnt_q       <= '0;
      addr_vld_q      <= 1'b0;
      data_vld_q      <= 1'b0;
      mem_wr_en_q     <= 1'b0;
      mem_wr_data_q   <= '0;
      cores_start_q   <= 1'b0;
      com_data_out_q  <= '0;
      ows_q           <= 1'b0;
      owd_q           <= 1'b0;
      load_overflow_q <= 1'b0;
    end else begin
      mem_wr_en_q   <= 1'b0;
      cores_start_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          // done may arrive alone; its word is still the last one written
          if (data_write_start || data_write_done) begin
            mem_wr_en_q   <= 1'b1;
            mem_addr_q    <= wr_addr_q;
            mem_wr_data_q <= com_data_in;
            wr_addr_q     <= wr_addr_d;
            if (&wr_addr_q) load_overflow_q <= 1'b1;
            if (data_write_done) begin
              state_q       <= ST_RUN;
              cores_start_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // cores_start_q marks the pulse cycle, where cores_done is not trusted
          if (!cores_start_q && cores_done) begin
            state_q     <= ST_DUMP;
            mem_addr_q  <= BASE_A;
            rd_ptr_q    <= BASE_NEXT;
            issue_cnt_q <= ONE_C;
            addr_vld_q  <= 1'b1;
            data_vld_q  <= 1'b0;
            out_cnt_q   <= '0;
          end
        end
        ST_DUMP: begin
          data_vld_q <= addr_vld_q;
          if (issue_cnt_q != LEN_C) begin
            mem_addr_q  <= rd_ptr_q;
            rd_ptr_q    <= rd_ptr_d;
            issue_cnt_q <= issue_cnt_q + ONE_C;
            addr_vld_q  <= 1'b1;
          end else begin
            addr_vld_q  <= 1'b0;
          end
          if (data_vld_q) begin
            com_data_out_q <= mem_rd_data;
            ows_q          <= 1'b1;
            out_cnt_q      <= out_cnt_q + ONE_C;
            if (out_cnt_q == LAST_C) begin
              owd_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          // DONE: outputs hold until reset
        end
      endcase
    end
  end

  assign state              = state_q;
  assign mem_wr_en          = mem_wr_en_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wr_data        = mem_wr_data_q;
  assign cores_start        = cores_start_q;
  assign com_data_out       = com_data_out_q;
  assign output_write_start = ows_q;
  assign output_write_done  = owd_q;
  assign load_overflow      = load_overflow_q;

endmodule

// File: tb/tb_host_com_port.sv
// Bench for host_com_port: random load streams against a memory-image
// model, plus directed reset, abort and single-word-region scenarios.
module tb_host_com_port;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int OB    = 2;
  localparam int OL    = 5;

  logic        clk, rst;
  logic [15:0] com_data_in, mem_rd_data, mem_wr_data, com_data_out;
  logic        dws, dwd, cores_done, mem_wr_en, cores_start, ows, owd, load_overflow;
  logic [AW-1:0] mem_addr;
  logic [1:0]  state;

  logic [15:0] com_b, rd_b, wrd_b, out_b;
  logic        dws_b, dwd_b, cd_b, we_b, cs_b, ows_b, owd_b, ovf_b;
  logic [AW-1:0] addr_b;
  logic [1:0]  state_b;

  host_com_port #(.DATA_W(16), .ADDR_W(AW), .OUT_BASE(OB), .OUT_LEN(OL)) dut (
    .clk(clk), .rst(rst), .com_data_in(com_data_in), .data_write_start(dws),
    .data_write_done(dwd), .cores_done(cores_done), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .cores_start(cores_start), .com_data_out(com_data_out),
    .output_write_start(ows), .output_write_done(owd), .state(state),
    .load_overflow(load_overflow));

  host_com_port #(.DATA_W(16), .ADDR_W(AW), .OUT_BASE(8), .OUT_LEN(1)) dut_one (
    .clk(clk), .rst(rst), .com_data_in(com_b), .data_write_start(dws_b),
    .data_write_done(dwd_b), .cores_done(cd_b), .mem_rd_data(rd_b),
    .mem_wr_en(we_b), .mem_addr(addr_b), .mem_wr_data(wrd_b),
    .cores_start(cs_b), .com_data_out(out_b),
    .output_write_start(ows_b), .output_write_done(owd_b), .state(state_b),
    .load_overflow(ovf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- memories (environment, 1-cycle read latency) -------------
  logic [15:0] mem_seed;
  logic [15:0] mem   [DEPTH];
  logic [15:0] mem_b [DEPTH];

  function automatic logic [15:0] init_word(input logic [15:0] seed, input int i);
    return seed ^ 16'(i * 16'h1111);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(mem_seed, i);
      mem_rd_data <= '0;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_b[i] <= (i == 8) ? 16'h1234 : 16'(i);
      rd_b <= '0;
    end else begin
      if (we_b) mem_b[addr_b] <= wrd_b;
      rd_b <= mem_b[addr_b];
    end
  end

  // ---------------- monitor for the main instance ---------------------------
  bit          mon_en = 0;
  int          tcyc, t_run, t_dump, t_first, t_lastout, t_lastwr, t_start, n_start;
  logic        owd_prev;
  logic [AW-1:0] wr_a [$];
  logic [15:0] wr_d [$];
  logic [15:0] out_d [$];
  logic        out_dn [$];

  always @(negedge clk) begin
    if (mon_en) begin
      tcyc++;
      if (mem_wr_en) begin
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_wr_data);
        t_lastwr = tcyc;
      end
      if (cores_start) begin
        n_start++;
        t_start = tcyc;
      end
      if (state == 2'd1 && t_run < 0) t_run = tcyc;
      if (state == 2'd2 && t_dump < 0) t_dump = tcyc;
      if (ows && !owd_prev) begin
        out_d.push_back(com_data_out);
        out_dn.push_back(owd);
        if (t_first < 0) t_first = tcyc;
        t_lastout = tcyc;
      end
      owd_prev = owd;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d, required 0", state); end
    n_cmp++; if (mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b, required 0", mem_wr_en); end
    n_cmp++; if (mem_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h, required 0", mem_addr); end
    n_cmp++; if (mem_wr_data !== '0) begin n_bad++; $display("FAIL reset_wr_data: got %h, required 0", mem_wr_data); end
    n_cmp++; if (cores_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b, required 0", cores_start); end
    n_cmp++; if (com_data_out !== '0) begin n_bad++; $display("FAIL reset_out: got %h, required 0", com_data_out); end
    n_cmp++; if (ows !== 1'b0 || owd !== 1'b0) begin n_bad++; $display("FAIL reset_ows_owd: got %b%b, required 00", ows, owd); end
    n_cmp++; if (load_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b, required 0", load_overflow); end
    rst = 1'b0;
    step();
    n_cmp++; if (state !== 2'd0 || mem_wr_en !== 1'b0) begin n_bad++; $display("FAIL idle_load: state %0d wr_en %b, required 0 0", state, mem_wr_en); end
    $display("txn reset: outputs checked during and after reset");
  endtask

  task automatic run_txn(input string name, input int n, input bit lowlast, input int cdel,
                         input int abort_after, input bit do_reset);
    logic [15:0] w [$];
    logic [15:0] exp_mem [DEPTH];
    int to, target, exp_dump;
    mon_en = 0;
    wr_a.delete(); wr_d.delete(); out_d.delete(); out_dn.delete();
    tcyc = 0; t_run = -1; t_dump = -1; t_first = -1; t_lastout = -1;
    t_lastwr = -1; t_start = -1; n_start = 0; owd_prev = 1'b0;
    dws = 1'b0; dwd = 1'b0; cores_done = (cdel < 0);
    if (do_reset) begin
      mem_seed = 16'($urandom);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
    end
    // model: memory image = initial contents overwritten by the stream, mod depth
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(mem_seed, i);
    for (int i = 0; i < n; i++) w.push_back(16'($urandom));
    for (int i = 0; i < n; i++) exp_mem[i % DEPTH] = w[i];
    mon_en = 1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        com_data_in = 16'($urandom); dws = 1'b0; dwd = 1'b0;
        step();
      end
      com_data_in = w[i];
      dwd = (i == n - 1);
      dws = !(lowlast && (i == n - 1));
      step();
    end
    dws = 1'b0;
    com_data_in = 16'($urandom);
    if (cdel >= 0) begin
      repeat (cdel) step();
      cores_done = 1'b1;
    end
    target = (abort_after > 0) ? abort_after : OL;
    to = 0;
    while (out_d.size() < target && to < 80) begin
      step();
      to++;
    end
    n_cmp++; if (out_d.size() < target) begin n_bad++; $display("FAIL %s timeout: got %0d words, required %0d", name, out_d.size(), target); end

    if (abort_after > 0) begin
      n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL %s pre_abort_state: got %0d, required 2", name, state); end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (ows !== 1'b0 || owd !== 1'b0) begin n_bad++; $display("FAIL %s async_ows: got %b%b, required 00", name, ows, owd); end
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL %s async_state: got %0d, required 0", name, state); end
      n_cmp++; if (com_data_out !== '0 || mem_addr !== '0) begin n_bad++; $display("FAIL %s async_clear: out %h addr %h, required 0 0", name, com_data_out, mem_addr); end
      cores_done = 1'b0; dwd = 1'b0;
      step();
      step();
      rst = 1'b0;
      mon_en = 0;
      $display("txn %s: n=%0d aborted after %0d words", name, n, out_d.size());
      return;
    end

    repeat (3) step();
    mon_en = 0;
    n_cmp++; if (wr_a.size() !== n) begin n_bad++; $display("FAIL %s wr_count: got %0d, required %0d", name, wr_a.size(), n); end
    for (int j = 0; j < wr_a.size() && j < n; j++) begin
      n_cmp++; if (wr_a[j] !== AW'(j % DEPTH) || wr_d[j] !== w[j]) begin
        n_bad++; $display("FAIL %s write[%0d]: got (%0d,%h), required (%0d,%h)", name, j, wr_a[j], wr_d[j], j % DEPTH, w[j]);
      end
    end
    n_cmp++; if (n_start !== 1 || t_start !== t_run) begin n_bad++; $display("FAIL %s start_pulse: got %0d pulses at %0d, required 1 at %0d", name, n_start, t_start, t_run); end
    n_cmp++; if (t_lastwr !== t_run) begin n_bad++; $display("FAIL %s run_entry: got last write at %0d, required RUN at %0d", name, t_lastwr, t_run); end
    exp_dump = t_run + ((cdel > 1) ? cdel : 1) + 1;
    n_cmp++; if (t_dump !== exp_dump) begin n_bad++; $display("FAIL %s dump_entry: got %0d, required %0d", name, t_dump, exp_dump); end
    n_cmp++; if (t_first !== t_dump + 2) begin n_bad++; $display("FAIL %s first_word: got %0d, required %0d", name, t_first, t_dump + 2); end
    n_cmp++; if (out_d.size() !== OL) begin n_bad++; $display("FAIL %s out_count: got %0d, required %0d", name, out_d.size(), OL); end
    for (int j = 0; j < out_d.size() && j < OL; j++) begin
      n_cmp++; if (out_d[j] !== exp_mem[OB + j] || out_dn[j] !== (j == OL - 1)) begin
        n_bad++; $display("FAIL %s out[%0d]: got %h done=%b, required %h done=%b", name, j, out_d[j], out_dn[j], exp_mem[OB + j], (j == OL - 1));
      end
    end
    n_cmp++; if (t_lastout - t_first !== OL - 1) begin n_bad++; $display("FAIL %s contiguous: got span %0d, required %0d", name, t_lastout - t_first, OL - 1); end
    n_cmp++; if (state !== 2'd3 || ows !== 1'b1 || owd !== 1'b1) begin n_bad++; $display("FAIL %s done_hold: got state %0d ows %b owd %b, required 3 1 1", name, state, ows, owd); end
    n_cmp++; if (com_data_out !== exp_mem[OB + OL - 1]) begin n_bad++; $display("FAIL %s out_hold: got %h, required %h", name, com_data_out, exp_mem[OB + OL - 1]); end
    n_cmp++; if (load_overflow !== (n >= DEPTH)) begin n_bad++; $display("FAIL %s overflow: got %b, required %b", name, load_overflow, (n >= DEPTH)); end
    $display("txn %s: n=%0d lowlast=%0d cdel=%0d writes=%0d outs=%0d", name, n, lowlast, cdel, wr_a.size(), out_d.size());
  endtask

  task automatic test_basic();         run_txn("basic", 3, 1'b0, 4, 0, 1'b1); endtask
  task automatic test_done_only_word(); run_txn("done_only", 1, 1'b1, 2, 0, 1'b1); endtask
  task automatic test_overflow();      run_txn("wrap", DEPTH + 1, 1'b0, 1, 0, 1'b1); endtask
  task automatic test_early_cores_done(); run_txn("early_done", 6, 1'b0, -1, 0, 1'b1); endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++)
      run_txn("random", $urandom_range(1, 20), 1'($urandom_range(0, 1)),
              $urandom_range(0, 6) - 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_dump();
    run_txn("abort", 8, 1'b0, 2, 2, 1'b1);
    run_txn("reload", 4, 1'b0, 3, 0, 1'b0);
  endtask

  task automatic test_single_out();
    logic [15:0] word;
    int to;
    dws_b = 1'b0; dwd_b = 1'b0; cd_b = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    word = 16'($urandom);
    com_b = word; dwd_b = 1'b1;
    step();
    n_cmp++; if (we_b !== 1'b1 || addr_b !== '0 || wrd_b !== word) begin n_bad++; $display("FAIL one_write: got en %b addr %0d data %h, required 1 0 %h", we_b, addr_b, wrd_b, word); end
    n_cmp++; if (state_b !== 2'd1 || cs_b !== 1'b1) begin n_bad++; $display("FAIL one_run: got state %0d start %b, required 1 1", state_b, cs_b); end
    cd_b = 1'b1;
    to = 0;
    while (!ows_b && to < 30) begin
      step();
      to++;
    end
    n_cmp++; if (to !== 4) begin n_bad++; $display("FAIL one_latency: got %0d cycles, required 4", to); end
    n_cmp++; if (out_b !== 16'h1234 || owd_b !== 1'b1) begin n_bad++; $display("FAIL one_word: got %h done=%b, required 1234 done=1", out_b, owd_b); end
    repeat (3) step();
    n_cmp++; if (state_b !== 2'd3 || ows_b !== 1'b1 || owd_b !== 1'b1 || out_b !== 16'h1234) begin
      n_bad++; $display("FAIL one_hold: got state %0d ows %b owd %b out %h, required 3 1 1 1234", state_b, ows_b, owd_b, out_b);
    end
    n_cmp++; if (ovf_b !== 1'b0) begin n_bad++; $display("FAIL one_ovf: got %b, required 0", ovf_b); end
    $display("txn single_out: word %h loaded, result %h", word, out_b);
  endtask

  initial begin
    rst = 1'b1; mem_seed = 16'h0;
    com_data_in = '0; dws = 1'b0; dwd = 1'b0; cores_done = 1'b0;
    com_b = '0; dws_b = 1'b0; dwd_b = 1'b0; cd_b = 1'b0;
    test_reset();
    test_basic();
    test_done_only_word();
    test_overflow();
    test_early_cores_done();
    test_random();
    test_reset_mid_dump();
    test_single_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_com_port.md
Name: host_com_port

Overview:
- Processor-side end of the host communication link.
- Receives the 16-bit word stream framed by data_write_start/data_write_done and writes it into shared data memory from address 0.
- Pulses the cores to start, waits for cores_done, then streams the result region back out on com_data_out, framed by output_write_start/output_write_done.
- Sits inside main, between the host pins, the data memory write/read port and the core controller.

Parameters:
- DATA_W, 16, width of link words and memory words.
- ADDR_W, 12, data memory address width.
- OUT_BASE, 0, first memory address of the result region.
- OUT_LEN, 64, number of result words streamed out; must be >=1 and OUT_BASE+OUT_LEN <= 2^ADDR_W (elaboration check).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- com_data_in  in  DATA_W  inbound host word.
- data_write_start  in  1  host is streaming words.
- data_write_done  in  1  current word is the last; stays high afterwards.
- cores_done  in  1  level; all enabled cores finished.
- mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after address.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address for both writes and reads.
- mem_wr_data  out  DATA_W  memory write data.
- cores_start  out  1  one-cycle start pulse to the cores.
- com_data_out  out  DATA_W  outbound result word.
- output_write_start  out  1  high while com_data_out carries valid result words.
- output_write_done  out  1  high with the final result word, then held.
- state  out  2  LOAD=0, RUN=1, DUMP=2, DONE=3.
- load_overflow  out  1  sticky; a load wrapped the address space.

Behaviour:
Reset (async, any state):
- state=LOAD; wr_addr=0.
- All outputs 0: mem_wr_en, mem_addr, mem_wr_data, cores_start, com_data_out, output_write_start, output_write_done, load_overflow.
- Reset mid-DUMP drops output_write_start immediately (async).

LOAD:
- On each posedge with data_write_start|data_write_done:
  - mem_wr_en=1, mem_addr=wr_addr, mem_wr_data=com_data_in (registered; write commits next cycle).
  - wr_addr increments.
- If data_write_done=1 in that cycle, that word is the last one and is still written. Next state is RUN.
- data_write_done may arrive with data_write_start already low; the word is still captured.
- wr_addr wraps at 2^ADDR_W-1 -> 0 and sets load_overflow (sticky until rst).
- Otherwise mem_wr_en=0.

RUN:
- First cycle: cores_start=1 for exactly one cycle; mem_wr_en=0.
- Wait for cores_done=1. cores_done sampled high in the same cycle as the start pulse is ignored; sampling begins the cycle after.
- Then go to DUMP with rd_ptr=OUT_BASE.

DUMP:
- Issue mem_addr=rd_ptr each cycle, rd_ptr++, for OUT_LEN addresses.
- With 1-cycle read latency, the first valid word appears on com_data_out 2 cycles after entering DUMP (address register + memory).
- output_write_start=1 exactly on the OUT_LEN cycles carrying valid words, contiguous, no bubbles.
- output_write_done=1 on the cycle of the last word; next state DONE.

DONE:
- output_write_done and output_write_start hold 1; com_data_out holds the last word.
- Remains until rst. Inputs are ignored.

General:
- Inputs are synchronous to clk; no synchronisers.
- data_write_done=1 outside LOAD is ignored.
- cores_done=1 during LOAD has no effect.

Decomposition:
- Shared definitions include: state encodings (LOAD/RUN/DUMP/DONE), DATA_W default, ADDR_W default.
- No sub-module needed: one FSM with write counter, read counter, and output pipeline register, all in one module.

Test Plan:
- Stream 5,6,7 (done asserted with 7), OUT_BASE=0, OUT_LEN=3, cores_done 4 cycles after start -> memory writes (0,5),(1,6),(2,7); single cores_start pulse; com_data_out 5,6,7 with output_write_start high 3 cycles and output_write_done on 7; state 0->1->2->3.
- Single word 0xBEEF with data_write_start=0, data_write_done=1 -> one write to addr 0, transition to RUN the next cycle.
- ADDR_W=2, stream 5 words -> addresses 0,1,2,3,0; load_overflow=1 after the 5th word; addr 0 holds word 5.
- cores_done held high from reset -> ignored during LOAD and the start-pulse cycle; DUMP starts 2 cycles after entering RUN.
- rst asserted mid-DUMP after 2 of 4 words -> asynchronous clear of outputs; state=LOAD; a new load restarts at addr 0.
- OUT_BASE=8, OUT_LEN=1, mem[8]=0x1234 -> exactly one output cycle with 0x1234 and output_write_start and output_write_done both high together, then held in DONE.
